// File: rtl/cmp_pkg.sv
// Shared constants and types for the magnitude comparator slice.
package cmp_pkg;

  // Default operand width for the min/max tracking datapath.
  localparam int DATA_W = 8;

  // Compare outcome, resolved once and then fanned out to the lt/eq/gt flags.
  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_res_e;

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude compare core: produces a<b and a==b for
// unsigned or two's-complement operands.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             eq
);

  logic [WIDTH-1:0] a_key;
  logic [WIDTH-1:0] b_key;

  // Inverting the sign bit maps two's-complement order onto unsigned order,
  // so a single unsigned compare serves both modes.
  always_comb begin
    a_key = a;
    b_key = b;
    if (SIGNED) begin
      a_key[WIDTH-1] = ~a[WIDTH-1];
      b_key[WIDTH-1] = ~b[WIDTH-1];
    end
  end

  // Equality does not depend on the mode.
  always_comb begin
    lt = (a_key < b_key);
    eq = (a == b);
  end

endmodule

// File: rtl/magnitude_comparator.sv
// Magnitude comparator: same-cycle a<b output plus a registered stage
// carrying lt/eq/gt flags and min/max of the operand pair.
module magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             c,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out,
  output logic             out_valid
);

  logic     core_lt;
  logic     core_eq;
  cmp_res_e res;
  logic [WIDTH-1:0] min_d;
  logic [WIDTH-1:0] max_d;

  cmp_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_core (
    .a  (a),
    .b  (b),
    .lt (core_lt),
    .eq (core_eq)
  );

  // c is taken straight from the core so callers can use it at the load edge.
  assign c = core_lt;

  // Resolve the outcome once; min/max favour a when the operands are equal.
  always_comb begin
    res   = CMP_GT;
    min_d = b;
    max_d = a;
    if (core_lt) begin
      res   = CMP_LT;
      min_d = a;
      max_d = b;
    end else if (core_eq) begin
      res   = CMP_EQ;
      min_d = a;
      max_d = a;
    end
  end

  // Result registers load only on valid input and hold otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      lt      <= 1'b0;
      eq      <= 1'b0;
      gt      <= 1'b0;
      min_out <= '0;
      max_out <= '0;
    end else if (in_valid) begin
      lt      <= (res == CMP_LT);
      eq      <= (res == CMP_EQ);
      gt      <= (res == CMP_GT);
      min_out <= min_d;
      max_out <= max_d;
    end
  end

  // Valid strobe follows in_valid with one cycle of latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_magnitude_comparator.sv
// Directed self-checking bench: 8-bit unsigned/signed instances for the
// named scenarios, 4-bit unsigned/signed instances for the full sweep.
module tb_magnitude_comparator;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [7:0] a8, b8;
  logic       iv8;
  logic [3:0] a4, b4;
  logic       iv4;

  logic       cu8, ltu8, equ8, gtu8, ovu8;
  logic [7:0] minu8, maxu8;
  logic       cs8, lts8, eqs8, gts8, ovs8;
  logic [7:0] mins8, maxs8;
  logic       cu4, ltu4, equ4, gtu4, ovu4;
  logic [3:0] minu4, maxu4;
  logic       cs4, lts4, eqs4, gts4, ovs4;
  logic [3:0] mins4, maxs4;

  int checks = 0;
  int errors = 0;

  magnitude_comparator #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
    .clock(clock), .reset(reset), .a(a8), .b(b8), .in_valid(iv8),
    .c(cu8), .lt(ltu8), .eq(equ8), .gt(gtu8),
    .min_out(minu8), .max_out(maxu8), .out_valid(ovu8));

  magnitude_comparator #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
    .clock(clock), .reset(reset), .a(a8), .b(b8), .in_valid(iv8),
    .c(cs8), .lt(lts8), .eq(eqs8), .gt(gts8),
    .min_out(mins8), .max_out(maxs8), .out_valid(ovs8));

  magnitude_comparator #(.WIDTH(4), .SIGNED(1'b0)) u_u4 (
    .clock(clock), .reset(reset), .a(a4), .b(b4), .in_valid(iv4),
    .c(cu4), .lt(ltu4), .eq(equ4), .gt(gtu4),
    .min_out(minu4), .max_out(maxu4), .out_valid(ovu4));

  magnitude_comparator #(.WIDTH(4), .SIGNED(1'b1)) u_s4 (
    .clock(clock), .reset(reset), .a(a4), .b(b4), .in_valid(iv4),
    .c(cs4), .lt(lts4), .eq(eqs4), .gt(gts4),
    .min_out(mins4), .max_out(maxs4), .out_valid(ovs4));

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; iv8 = 1'b1; iv4 = 1'b1;
    a8 = 8'd9; b8 = 8'd4; a4 = 4'd3; b4 = 4'd1;
    tick(); tick();
    checks++;
    if ({ltu8, equ8, gtu8, ovu8, minu8, maxu8} !== 20'h0) begin
      errors++;
      $display("FAIL reset_u8 got %0h exp 0", {ltu8, equ8, gtu8, ovu8, minu8, maxu8});
    end
    checks++;
    if ({lts8, eqs8, gts8, ovs8, mins8, maxs8} !== 20'h0) begin
      errors++;
      $display("FAIL reset_s8 got %0h exp 0", {lts8, eqs8, gts8, ovs8, mins8, maxs8});
    end
    checks++;
    if ({ltu4, equ4, gtu4, ovu4, minu4, maxu4, lts4, eqs4, gts4, ovs4, mins4, maxs4} !== 24'h0) begin
      errors++;
      $display("FAIL reset_4 got %0h exp 0",
               {ltu4, equ4, gtu4, ovu4, minu4, maxu4, lts4, eqs4, gts4, ovs4, mins4, maxs4});
    end
    reset = 1'b0; iv8 = 1'b0; iv4 = 1'b0;
    tick();
  endtask

  task automatic test_unsigned_basic();
    a8 = 8'd3; b8 = 8'd5; iv8 = 1'b1;
    #1;
    checks++;
    if (cu8 !== 1'b1) begin errors++; $display("FAIL basic_c got %0b exp 1", cu8); end
    tick();
    checks++;
    if ({ltu8, equ8, gtu8, ovu8} !== 4'b1001) begin
      errors++; $display("FAIL basic_flags got %b exp 1001", {ltu8, equ8, gtu8, ovu8});
    end
    checks++;
    if ({minu8, maxu8} !== {8'd3, 8'd5}) begin
      errors++; $display("FAIL basic_minmax got %0d/%0d exp 3/5", minu8, maxu8);
    end
  endtask

  task automatic test_equal_extremes();
    a8 = 8'd5; b8 = 8'd5; iv8 = 1'b1;
    #1;
    checks++;
    if (cu8 !== 1'b0) begin errors++; $display("FAIL eq_c got %0b exp 0", cu8); end
    tick();
    checks++;
    if ({ltu8, equ8, gtu8, minu8, maxu8} !== {3'b010, 8'd5, 8'd5}) begin
      errors++; $display("FAIL eq_regs got %b %0d %0d exp 010 5 5", {ltu8, equ8, gtu8}, minu8, maxu8);
    end
    a8 = 8'd255; b8 = 8'd0;
    #1;
    checks++;
    if (cu8 !== 1'b0) begin errors++; $display("FAIL ext_c got %0b exp 0", cu8); end
    tick();
    checks++;
    if ({ltu8, equ8, gtu8, minu8, maxu8} !== {3'b001, 8'd0, 8'd255}) begin
      errors++; $display("FAIL ext_regs got %b %0d %0d exp 001 0 255", {ltu8, equ8, gtu8}, minu8, maxu8);
    end
  endtask

  task automatic test_signed();
    a8 = 8'hFF; b8 = 8'h00; iv8 = 1'b1;
    #1;
    checks++;
    if ({cs8, cu8} !== 2'b10) begin errors++; $display("FAIL sgn_c got s%0b u%0b exp s1 u0", cs8, cu8); end
    tick();
    checks++;
    if ({lts8, eqs8, gts8, mins8, maxs8} !== {3'b100, 8'hFF, 8'h00}) begin
      errors++; $display("FAIL sgn_regs got %b %0h %0h exp 100 ff 0", {lts8, eqs8, gts8}, mins8, maxs8);
    end
    checks++;
    if ({ltu8, equ8, gtu8, minu8, maxu8} !== {3'b001, 8'h00, 8'hFF}) begin
      errors++; $display("FAIL uns_ff_regs got %b %0h %0h exp 001 0 ff", {ltu8, equ8, gtu8}, minu8, maxu8);
    end
    a8 = 8'h80; b8 = 8'h7F;
    #1;
    checks++;
    if ({cs8, cu8} !== 2'b10) begin errors++; $display("FAIL sgn_80_c got s%0b u%0b exp s1 u0", cs8, cu8); end
    tick();
    checks++;
    if ({lts8, mins8, maxs8} !== {1'b1, 8'h80, 8'h7F}) begin
      errors++; $display("FAIL sgn_80_regs got %b %0h %0h exp 1 80 7f", lts8, mins8, maxs8);
    end
  endtask

  task automatic test_back_to_back();
    a8 = 8'd10; b8 = 8'd20; iv8 = 1'b1;
    tick();
    checks++;
    if ({ltu8, equ8, gtu8, ovu8} !== 4'b1001) begin
      errors++; $display("FAIL b2b_0 got %b exp 1001", {ltu8, equ8, gtu8, ovu8});
    end
    a8 = 8'd30; b8 = 8'd20;
    tick();
    checks++;
    if ({ltu8, equ8, gtu8, ovu8, minu8, maxu8} !== {4'b0011, 8'd20, 8'd30}) begin
      errors++; $display("FAIL b2b_1 got %b %0d %0d exp 0011 20 30", {ltu8, equ8, gtu8, ovu8}, minu8, maxu8);
    end
    a8 = 8'd7; b8 = 8'd7;
    tick();
    checks++;
    if ({ltu8, equ8, gtu8, ovu8} !== 4'b0101) begin
      errors++; $display("FAIL b2b_2 got %b exp 0101", {ltu8, equ8, gtu8, ovu8});
    end
    a8 = 8'd100; b8 = 8'd1; iv8 = 1'b0;
    tick();
    checks++;
    if ({ltu8, equ8, gtu8, ovu8, minu8, maxu8} !== {4'b0100, 8'd7, 8'd7}) begin
      errors++; $display("FAIL hold got %b %0d %0d exp 0100 7 7", {ltu8, equ8, gtu8, ovu8}, minu8, maxu8);
    end
  endtask

  task automatic test_reset_mid();
    a8 = 8'd1; b8 = 8'd2; iv8 = 1'b1; reset = 1'b1;
    #1;
    checks++;
    if (cu8 !== 1'b1) begin errors++; $display("FAIL rst_c_pre got %0b exp 1", cu8); end
    tick();
    checks++;
    if ({ltu8, equ8, gtu8, ovu8, minu8, maxu8} !== 20'h0) begin
      errors++; $display("FAIL rst_mid got %0h exp 0", {ltu8, equ8, gtu8, ovu8, minu8, maxu8});
    end
    checks++;
    if (cu8 !== 1'b1) begin errors++; $display("FAIL rst_c_post got %0b exp 1", cu8); end
    reset = 1'b0; iv8 = 1'b0;
    tick();
  endtask

  task automatic test_sweep4();
    int ia, ib, sa, sb;
    logic [2:0] fu, fs;
    logic [3:0] mnu, mxu, mns, mxs;
    logic       cu_exp, cs_exp;
    int sweep_errs = 0;
    iv4 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a4 = i[7:4]; b4 = i[3:0];
      ia = int'(a4); ib = int'(b4);
      sa = (ia >= 8) ? ia - 16 : ia;
      sb = (ib >= 8) ? ib - 16 : ib;
      cu_exp = (ia < ib);
      cs_exp = (sa < sb);
      fu = {ia < ib, ia == ib, ia > ib};
      fs = {sa < sb, sa == sb, sa > sb};
      mnu = (ib < ia) ? b4 : a4;  mxu = (ib > ia) ? b4 : a4;
      mns = (sb < sa) ? b4 : a4;  mxs = (sb > sa) ? b4 : a4;
      #1;
      checks++;
      if ({cu4, cs4} !== {cu_exp, cs_exp}) begin
        errors++; sweep_errs++;
        if (sweep_errs < 10) $display("FAIL sweep_c a=%0h b=%0h got %b exp %b", a4, b4, {cu4, cs4}, {cu_exp, cs_exp});
      end
      tick();
      checks++;
      if ({ltu4, equ4, gtu4, ovu4, minu4, maxu4} !== {fu, 1'b1, mnu, mxu} || !$onehot({ltu4, equ4, gtu4})) begin
        errors++; sweep_errs++;
        if (sweep_errs < 10) $display("FAIL sweep_u a=%0h b=%0h got %b %0h %0h exp %b %0h %0h",
                                      a4, b4, {ltu4, equ4, gtu4}, minu4, maxu4, fu, mnu, mxu);
      end
      checks++;
      if ({lts4, eqs4, gts4, ovs4, mins4, maxs4} !== {fs, 1'b1, mns, mxs} || !$onehot({lts4, eqs4, gts4})) begin
        errors++; sweep_errs++;
        if (sweep_errs < 10) $display("FAIL sweep_s a=%0h b=%0h got %b %0h %0h exp %b %0h %0h",
                                      a4, b4, {lts4, eqs4, gts4}, mins4, maxs4, fs, mns, mxs);
      end
    end
    iv4 = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; iv8 = 1'b0; iv4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    #2;
    test_reset();
    test_unsigned_basic();
    test_equal_extremes();
    test_signed();
    test_back_to_back();
    test_reset_mid();
    test_sweep4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/magnitude_comparator.md
Name:
magnitude_comparator

Overview:
- WIDTH-bit magnitude comparator used by the min/max tracking datapath to decide whether an incoming sample is below the current smallest or largest value.
- Combinational output `c` = (a < b), usable in the same cycle as the inputs.
- A registered result stage adds lt/eq/gt flags and min/max of the two operands, qualified by a valid strobe.

Parameters:
- WIDTH, 8, operand width in bits (>= 1).
- SIGNED, 0, 0 = unsigned compare; 1 = two's-complement compare (affects `c` and all registered outputs).

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  left operand (data sample).
- b  input  WIDTH  right operand (reference value).
- in_valid  input  1  qualifies a/b for the registered stage.
- c  output  1  combinational: 1 iff a < b under the SIGNED mode; no clock or reset dependence.
- lt  output  1  registered: a < b.
- eq  output  1  registered: a == b.
- gt  output  1  registered: a > b.
- min_out  output  WIDTH  registered: the smaller operand (a if equal).
- max_out  output  WIDTH  registered: the larger operand (a if equal).
- out_valid  output  1  registered: in_valid delayed one cycle.

Behaviour:
- Reset: synchronous, active-high, highest priority.
  - In any cycle with reset=1, the next edge clears lt, eq, gt, min_out, max_out and out_valid to 0, regardless of in_valid.
- `c` is purely combinational from a and b.
  - Settles within the cycle.
  - Unaffected by reset, so the caller can sample it at the same edge it loads data.
- Compare rule:
  - SIGNED=0: operands are unsigned 0..2^WIDTH-1.
  - SIGNED=1: the MSB is the sign bit.
  - Equal operands: c=0, eq=1.
- Registered stage, 1-cycle latency:
  - On an edge with in_valid=1 and reset=0: lt/eq/gt/min_out/max_out load from the current a, b, and out_valid becomes 1.
  - On an edge with in_valid=0 and reset=0: out_valid becomes 0 and all other registered outputs hold their last values.
- Exactly one of lt/eq/gt is 1 whenever out_valid=1 or any compare has completed since reset; all three are 0 after reset.
- Back-to-back valid inputs: one result per cycle, no stalls, no backpressure.
- No internal state beyond the output registers; no overflow possible (no arithmetic widening).
- Reset asserted mid-stream: the pending result is discarded, and out_valid=0 in the cycle after the reset edge.

Decomposition:
- Shared package (cmp_pkg):
  - DATA_W = 8 default width constant.
  - Enum cmp_res_e {CMP_LT, CMP_EQ, CMP_GT}, used internally to encode the result before fan-out to flags.
- One sub-module, cmp_core:
  - Combinational, parameterized WIDTH/SIGNED.
  - Produces lt and eq from a, b.
  - Instantiated once; `c` = lt from cmp_core; gt = !lt & !eq.
  - Registered stage in the top.

Test Plan:
- Unsigned basic: WIDTH=8, SIGNED=0, a=3, b=5, in_valid=1 -> c=1 same cycle; next edge lt=1, eq=0, gt=0, min_out=3, max_out=5, out_valid=1.
- Equality and extremes:
  - a=5, b=5 -> c=0; next edge eq=1, min_out=5, max_out=5.
  - a=255, b=0 -> c=0, gt=1, min_out=0, max_out=255.
- Signed mode: SIGNED=1, a=8'hFF (-1), b=8'h00 -> c=1, lt=1, min_out=8'hFF, max_out=8'h00; a=8'h80, b=8'h7F -> c=1.
- Hold and streaming:
  - Valid pairs (10,20), (30,20), (7,7) on consecutive cycles -> lt, gt, eq on consecutive cycles with out_valid=1.
  - Then in_valid=0 -> out_valid=0, eq=1 and min/max=7 held.
- Reset mid-operation: in_valid=1 with a=1, b=2 and reset=1 in the same cycle -> after the edge all registered outputs 0 and out_valid=0, while c=1 throughout.
- Exhaustive sweep, WIDTH=4 both modes: all 256 a/b pairs against a reference model -> c, lt/eq/gt, min/max match; one-hot flags.
